// File: rtl/peripheral_bfm_memory_wb_pkg.sv
// Shared definitions for the Wishbone B4 memory model: cycle-type and
// burst-type codes, FSM state encoding and a burst-continuation helper.
package peripheral_bfm_memory_wb_pkg;

    localparam logic [2:0] CTI_CLASSIC   = 3'b000;
    localparam logic [2:0] CTI_INC_BURST = 3'b010;
    localparam logic [2:0] CTI_END_BURST = 3'b111;

    localparam logic [1:0] BTE_LINEAR = 2'b00;
    localparam logic [1:0] BTE_WRAP4  = 2'b01;
    localparam logic [1:0] BTE_WRAP8  = 2'b10;
    localparam logic [1:0] BTE_WRAP16 = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLASSIC,
        ST_BURST
    } state_e;

    // Only an incrementing burst keeps the burst alive; every other code
    // (classic, end-of-burst, reserved) terminates after the current beat.
    function automatic logic cti_continues(input logic [2:0] cti);
        case (cti)
            CTI_INC_BURST:              return 1'b1;
            CTI_CLASSIC, CTI_END_BURST: return 1'b0;
            default:                    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/peripheral_bfm_memory_wb_addr_gen.sv
// Next word address for Wishbone incrementing bursts.
// Ports: word_i current word index, bte_i burst type, next_o next word index.
module peripheral_bfm_memory_wb_addr_gen
    import peripheral_bfm_memory_wb_pkg::*;
#(
    parameter int WW = 30
) (
    input  logic [WW-1:0] word_i,
    input  logic [1:0]    bte_i,
    output logic [WW-1:0] next_o
);

    logic [WW-1:0] mask;
    logic [WW-1:0] inc;

    // Bits under the mask advance, bits above it are held; a full mask
    // gives a plain linear increment.
    always_comb begin
        mask = '1;
        unique case (bte_i)
            BTE_LINEAR: mask = '1;
            BTE_WRAP4:  mask = WW'(3);
            BTE_WRAP8:  mask = WW'(7);
            BTE_WRAP16: mask = WW'(15);
            default:    mask = '1;
        endcase
        inc    = word_i + WW'(1);
        next_o = (word_i & ~mask) | (inc & mask);
    end

endmodule

// File: rtl/peripheral_bfm_memory_wb.sv
// Wishbone B4 slave memory model with classic and incrementing bursts.
// Ports: wb_clk_i/wb_rst_i clock and sync reset, wb_*_i slave inputs,
// wb_dat_o read data, wb_ack_o/wb_err_o/wb_rty_o registered terminations.
module peripheral_bfm_memory_wb
    import peripheral_bfm_memory_wb_pkg::*;
#(
    parameter int DEBUG     = 0,
    parameter int DW        = 32,
    parameter int AW        = 32,
    parameter int MEM_BYTES = 32768
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic [AW-1:0]   wb_adr_i,
    input  logic [DW-1:0]   wb_dat_i,
    input  logic [DW/8-1:0] wb_sel_i,
    input  logic            wb_we_i,
    input  logic            wb_cyc_i,
    input  logic            wb_stb_i,
    input  logic [2:0]      wb_cti_i,
    input  logic [1:0]      wb_bte_i,
    output logic [DW-1:0]   wb_dat_o,
    output logic            wb_ack_o,
    output logic            wb_err_o,
    output logic            wb_rty_o
);

    localparam int NB        = DW / 8;
    localparam int LSB       = (NB > 1) ? $clog2(NB) : 0;
    localparam int WW        = AW - LSB;
    localparam int MEM_WORDS = MEM_BYTES / NB;
    localparam int MW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    state_e          state_q, state_d;
    logic            ack_q, ack_d;
    logic            err_q, err_d;
    logic [DW-1:0]   dat_q, dat_d;
    logic [WW-1:0]   baddr_q, baddr_d;

    logic [DW-1:0]   mem_q [MEM_WORDS] = '{default: '0};

    logic            req;
    logic            done;
    logic            burst_cti;
    logic            beat_go;
    logic            beat_in_range;
    logic            adr_in_range;
    logic            mem_wr;
    logic [WW-1:0]   adr_word;
    logic [WW-1:0]   beat_word;
    logic [WW-1:0]   beat_next;
    logic [MW-1:0]   beat_idx;
    logic [MW-1:0]   wr_idx;

    if (LSB > 0) begin : g_lsb
        logic unused_lsb;
        assign unused_lsb = ^wb_adr_i[LSB-1:0];
    end

    assign req       = wb_cyc_i & wb_stb_i;
    assign done      = req & (ack_q | err_q);
    assign burst_cti = cti_continues(wb_cti_i);
    assign adr_word  = wb_adr_i[AW-1:LSB];

    // Beats after the first in a burst are served from the internally
    // generated address so read data is ready with zero wait states.
    assign beat_word     = (state_q == ST_BURST) ? baddr_q : adr_word;
    assign beat_in_range = beat_word < WW'(MEM_WORDS);
    assign adr_in_range  = adr_word < WW'(MEM_WORDS);
    assign beat_idx      = beat_word[MW-1:0];
    assign wr_idx        = adr_word[MW-1:0];

    // A beat terminated by err, or cut short by reset, never writes.
    assign mem_wr = done & wb_we_i & ack_q & adr_in_range & ~wb_rst_i;

    peripheral_bfm_memory_wb_addr_gen #(
        .WW (WW)
    ) u_addr_gen (
        .word_i (beat_word),
        .bte_i  (wb_bte_i),
        .next_o (beat_next)
    );

    always_comb begin
        state_d = state_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        dat_d   = '0;
        baddr_d = baddr_q;
        beat_go = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    beat_go = 1'b1;
                    state_d = burst_cti ? ST_BURST : ST_CLASSIC;
                end
            end
            ST_CLASSIC: state_d = ST_IDLE;
            ST_BURST: begin
                if (done && burst_cti) begin
                    beat_go = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (beat_go) begin
            ack_d   = beat_in_range;
            err_d   = ~beat_in_range;
            dat_d   = beat_in_range ? mem_q[beat_idx] : '0;
            baddr_d = beat_next;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= '0;
            baddr_q <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            dat_q   <= dat_d;
            baddr_q <= baddr_d;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (mem_wr) begin
            for (int b = 0; b < NB; b++) begin
                if (wb_sel_i[b]) begin
                    mem_q[wr_idx][8*b +: 8] <= wb_dat_i[8*b +: 8];
                end
            end
        end
    end

    assign wb_dat_o = dat_q;
    assign wb_ack_o = ack_q;
    assign wb_err_o = err_q;
    assign wb_rty_o = 1'b0;

`ifndef SYNTHESIS
    if (DEBUG != 0) begin : g_debug
        always @(posedge wb_clk_i) begin
            if (!wb_rst_i && done) begin
                $display("%m: %s %s adr=%h dat=%h sel=%b",
                         wb_we_i ? "WR" : "RD", ack_q ? "ack" : "err",
                         wb_adr_i, wb_we_i ? wb_dat_i : dat_q, wb_sel_i);
            end
        end
    end
`endif

endmodule

// File: tb/tb_peripheral_bfm_memory_wb.sv
// Randomised scoreboard bench for the Wishbone memory model.
// Driver pushes expected terminations; a negedge monitor pops and compares.
module tb_peripheral_bfm_memory_wb;

    localparam int MEM_BYTES = 32768;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] adr;
    logic [31:0] dat_i;
    logic [3:0]  sel;
    logic        we;
    logic        cyc;
    logic        stb;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic [31:0] dat_o;
    logic        ack;
    logic        err;
    logic        rty;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit          is_err;
        bit          chk;
        logic [31:0] data;
        string       name;
    } exp_t;

    exp_t        exp_q [$];
    logic [31:0] model [int unsigned];

    always #5 clk = ~clk;

    peripheral_bfm_memory_wb #(
        .DEBUG     (0),
        .DW        (32),
        .AW        (32),
        .MEM_BYTES (MEM_BYTES)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wb_adr_i (adr),
        .wb_dat_i (dat_i),
        .wb_sel_i (sel),
        .wb_we_i  (we),
        .wb_cyc_i (cyc),
        .wb_stb_i (stb),
        .wb_cti_i (cti),
        .wb_bte_i (bte),
        .wb_dat_o (dat_o),
        .wb_ack_o (ack),
        .wb_err_o (err),
        .wb_rty_o (rty)
    );

    function automatic logic [31:0] mread(input logic [31:0] a);
        if (a >= MEM_BYTES) return 32'h0;
        if (model.exists(a >> 2)) return model[a >> 2];
        return 32'h0;
    endfunction

    function automatic void mwrite(input logic [31:0] a, input logic [31:0] d,
                                   input logic [3:0] s);
        logic [31:0] w;
        if (a >= MEM_BYTES) return;
        w = mread(a);
        for (int b = 0; b < 4; b++) begin
            if (s[b]) w[8*b +: 8] = d[8*b +: 8];
        end
        model[a >> 2] = w;
    endfunction

    // Byte address of the following beat: linear adds one word, wrap-N
    // stays inside the aligned block of N words.
    function automatic logic [31:0] next_addr(input logic [31:0] a,
                                              input logic [1:0] bt);
        int unsigned span;
        int unsigned base;
        if (bt == 2'd0) return a + 32'd4;
        span = 32'd8 << bt;
        base = a - (a % span);
        return base + ((a - base + 32'd4) % span);
    endfunction

    function automatic void push_exp(input logic [31:0] a, input bit w,
                                     input string nm);
        exp_t e;
        e.is_err = (a >= MEM_BYTES);
        e.chk    = !w || e.is_err;
        e.data   = mread(a);
        e.name   = nm;
        exp_q.push_back(e);
    endfunction

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s got=%h required=%h", nm, got, req);
        end
    endtask

    task automatic wait_term(input int maxn, output int n);
        int k;
        bit hit;
        k   = 0;
        hit = 1'b0;
        while (!hit && k < maxn) begin
            @(negedge clk);
            k++;
            hit = ack || err;
        end
        n = hit ? k : -1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (ack || err) begin
            checks++;
            if (ack && err) begin
                failures++;
                $display("FAIL ack_err_both got ack=1 err=1 required one-hot");
            end else if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_term got ack=%0b err=%0b required none",
                         ack, err);
            end else begin
                e = exp_q.pop_front();
                if (err != e.is_err) begin
                    failures++;
                    $display("FAIL %s_kind got err=%0b required err=%0b",
                             e.name, err, e.is_err);
                end
                if (e.chk) begin
                    checks++;
                    if (dat_o !== e.data) begin
                        failures++;
                        $display("FAIL %s_data got=%h required=%h",
                                 e.name, dat_o, e.data);
                    end
                end
            end
        end
    end

    task automatic classic(input logic [31:0] a, input bit w,
                           input logic [31:0] d, input logic [3:0] s);
        int n;
        @(posedge clk);
        #1;
        adr   = a;
        we    = w;
        dat_i = d;
        sel   = s;
        cti   = 3'b000;
        bte   = 2'b00;
        cyc   = 1'b1;
        stb   = 1'b1;
        push_exp(a, w, "classic");
        wait_term(6, n);
        // n counts negedges from the drive point: 2 means one clock latency.
        chk("classic_latency", n, 2);
        if (n < 0) exp_q.delete();
        if (n > 0 && w) mwrite(a, d, s);
        @(posedge clk);
        #1;
        cyc = 1'b0;
        stb = 1'b0;
        we  = 1'b0;
    endtask

    task automatic burst(input logic [31:0] a0, input logic [1:0] bt,
                         input int nb, input bit w, input logic [31:0] base,
                         input int abort_at);
        logic [31:0] a;
        int n;
        a = a0;
        @(posedge clk);
        #1;
        for (int i = 0; i < nb; i++) begin
            adr   = a;
            we    = w;
            dat_i = base + 32'(i);
            sel   = 4'hF;
            bte   = bt;
            cti   = (i == nb - 1) ? 3'b111 : 3'b010;
            cyc   = 1'b1;
            stb   = 1'b1;
            push_exp(a, w, "burst");
            wait_term((i == 0) ? 6 : 1, n);
            chk("burst_latency", n, (i == 0) ? 2 : 1);
            if (n < 0) begin
                exp_q.delete();
                break;
            end
            if (i == abort_at) begin
                rst = 1'b1;
                @(posedge clk);
                #1;
                chk("rst_ack_low", {30'd0, ack, err}, 32'd0);
                rst = 1'b0;
                cyc = 1'b0;
                stb = 1'b0;
                we  = 1'b0;
                return;
            end
            if (w) mwrite(a, base + 32'(i), 4'hF);
            a = next_addr(a, bt);
            @(posedge clk);
            #1;
        end
        chk("burst_end", {30'd0, ack, err}, 32'd0);
        cyc = 1'b0;
        stb = 1'b0;
        we  = 1'b0;
        cti = 3'b000;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        logic [1:0]  bt;
        int          r;
        int          nb;
        bit          w;

        rst   = 1'b1;
        adr   = '0;
        dat_i = '0;
        sel   = '0;
        we    = 1'b0;
        cyc   = 1'b0;
        stb   = 1'b0;
        cti   = 3'b000;
        bte   = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", {31'd0, ack}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_rty", {31'd0, rty}, 32'd0);
        chk("rst_dat", dat_o, 32'd0);
        rst = 1'b0;

        classic(32'h100, 1'b1, 32'hDEADBEEF, 4'hF);
        classic(32'h100, 1'b0, 32'h0, 4'hF);
        classic(32'h100, 1'b1, 32'h000000AA, 4'h1);
        classic(32'h100, 1'b0, 32'h0, 4'h0);
        chk("model_byte_merge", mread(32'h100), 32'hDEADBEAA);

        burst(32'h200, 2'd0, 4, 1'b1, 32'd1, -1);
        burst(32'h200, 2'd0, 4, 1'b0, 32'd0, -1);
        burst(32'h208, 2'd1, 4, 1'b0, 32'd0, -1);

        classic(32'h8000, 1'b0, 32'h0, 4'hF);
        classic(32'h8000, 1'b1, 32'h12345678, 4'hF);
        classic(32'h0, 1'b0, 32'h0, 4'hF);
        classic(32'h7FFC, 1'b1, 32'hCAFEF00D, 4'hF);
        burst(32'h7FF8, 2'd0, 3, 1'b0, 32'd0, -1);

        for (int it = 0; it < 150; it++) begin
            r = int'($urandom_range(0, 9));
            w = 1'(($urandom_range(0, 1)));
            d = $urandom;
            if (r < 5) begin
                if (r == 0) a = 32'h8000 + 32'(4 * $urandom_range(0, 63));
                else        a = 32'(4 * $urandom_range(0, 255));
                s = 4'($urandom_range(0, 15));
                classic(a, w, d, s);
            end else begin
                a  = 32'(4 * $urandom_range(0, 255));
                bt = 2'($urandom_range(0, 3));
                nb = int'($urandom_range(1, 8));
                burst(a, bt, nb, w, d, -1);
            end
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
            end
        end

        burst(32'h300, 2'd0, 4, 1'b1, 32'hA0, 2);
        classic(32'h300, 1'b0, 32'h0, 4'hF);
        classic(32'h304, 1'b0, 32'h0, 4'hF);
        classic(32'h308, 1'b0, 32'h0, 4'hF);
        classic(32'h100, 1'b0, 32'h0, 4'hF);

        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_drain", exp_q.size(), 32'd0);
        chk("rty_const", {31'd0, rty}, 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
